// File: rtl/sram_ctrl_pkg.sv
// Shared types and default timing for the SRAM access sequencer.
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    ACC   = 3'd2,
    SENSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int unsigned DEF_COLS  = 8;
  localparam int unsigned DEF_ROWS  = 16;
  localparam int unsigned DEF_T_PRE = 2;
  localparam int unsigned DEF_T_WL  = 3;
  localparam int unsigned DEF_T_SA  = 2;

  // Largest of three phase lengths; sizes the shared phase counter.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sram_phase_timer.sv
// Loadable phase down-counter; done_c flags the last cycle of a loaded phase.
module sram_phase_timer #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done_c
);

  logic [W-1:0] count;

  // Load a phase length, then count down to zero and park there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done_c = (count == W'(1));

endmodule

// File: rtl/sram_access_ctrl.sv
// Single-port SRAM access sequencer: precharge -> wordline(/write) -> sense -> done.
// Optional write-verify readback pass: define SRAM_ACCESS_CTRL_WRITE_VERIFY_EN.
module sram_access_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter  int unsigned COLS   = DEF_COLS,
  parameter  int unsigned ROWS   = DEF_ROWS,
  parameter  int unsigned T_PRE  = DEF_T_PRE,
  parameter  int unsigned T_WL   = DEF_T_WL,
  parameter  int unsigned T_SA   = DEF_T_SA,
  localparam int unsigned ADDR_W = $clog2(ROWS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [COLS-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [COLS-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic              pre_en,
  output logic              wl_en,
  output logic [ADDR_W-1:0] wl_addr,
  output logic              wr_en,
  output logic [COLS-1:0]   wr_data,
  output logic              sae,
  input  logic [COLS-1:0]   sa_data
);

  localparam int unsigned CNT_W = $clog2(max3(T_PRE, T_WL, T_SA) + 1);

`ifdef SRAM_ACCESS_CTRL_WRITE_VERIFY_EN
  localparam bit VERIFY_EN = 1'b1;
  logic verify;
`else
  localparam bit VERIFY_EN = 1'b0;
  logic verify;
  assign verify = 1'b0;
`endif

  state_t              state;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [COLS-1:0]     lat_wdata;
  logic                tmr_load_c;
  logic [CNT_W-1:0]    tmr_val_c;
  logic                tmr_done_c;
  logic                accept_c;
  logic                drive_wr_c;

  assign accept_c   = req_valid && req_ready;
  // The write driver is used only on the first pass of a write, never on the verify readback.
  assign drive_wr_c = lat_we && !verify;

  sram_phase_timer #(.W(CNT_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load_c),
    .value  (tmr_val_c),
    .done_c (tmr_done_c)
  );

  // Pick the next phase length at each phase boundary.
  always_comb begin
    tmr_load_c = 1'b0;
    tmr_val_c  = '0;
    case (state)
      IDLE: begin
        if (accept_c) begin
          tmr_load_c = 1'b1;
          tmr_val_c  = CNT_W'(T_PRE);
        end
      end
      PRE: begin
        if (tmr_done_c) begin
          tmr_load_c = 1'b1;
          tmr_val_c  = CNT_W'(T_WL);
        end
      end
      ACC: begin
        if (tmr_done_c) begin
          if (drive_wr_c) begin
            tmr_load_c = VERIFY_EN;
            tmr_val_c  = CNT_W'(T_PRE);
          end else begin
            tmr_load_c = 1'b1;
            tmr_val_c  = CNT_W'(T_SA);
          end
        end
      end
      default: ;
    endcase
  end

  // Sequencer: state and every phase/response output change together on the clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      pre_en    <= 1'b0;
      wl_en     <= 1'b0;
      wl_addr   <= '0;
      wr_en     <= 1'b0;
      wr_data   <= '0;
      sae       <= 1'b0;
`ifdef SRAM_ACCESS_CTRL_WRITE_VERIFY_EN
      verify    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (accept_c) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            req_ready <= 1'b0;
            pre_en    <= 1'b1;
            state     <= PRE;
          end
        end
        PRE: begin
          if (tmr_done_c) begin
            pre_en  <= 1'b0;
            wl_en   <= 1'b1;
            wl_addr <= lat_addr;
            wr_en   <= drive_wr_c;
            wr_data <= drive_wr_c ? lat_wdata : '0;
            state   <= ACC;
          end
        end
        ACC: begin
          if (tmr_done_c) begin
            wl_en   <= 1'b0;
            wl_addr <= '0;
            wr_en   <= 1'b0;
            wr_data <= '0;
            if (drive_wr_c) begin
`ifdef SRAM_ACCESS_CTRL_WRITE_VERIFY_EN
              verify <= 1'b1;
              pre_en <= 1'b1;
              state  <= PRE;
`else
              rsp_valid <= 1'b1;
              state     <= DONE;
`endif
            end else begin
              sae   <= 1'b1;
              state <= SENSE;
            end
          end
        end
        SENSE: begin
          if (tmr_done_c) begin
            sae       <= 1'b0;
            rsp_rdata <= sa_data;
            rsp_valid <= 1'b1;
`ifdef SRAM_ACCESS_CTRL_WRITE_VERIFY_EN
            rsp_err   <= verify && (sa_data != lat_wdata);
            verify    <= 1'b0;
`endif
            state     <= DONE;
          end
        end
        DONE: begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Self-checking bench for sram_access_ctrl with a behavioural bitcell array model.
module tb_sram_access_ctrl;

  localparam int COLS = 8;
  localparam int ROWS = 16;
  localparam int TP   = 2;
  localparam int TW   = 3;
  localparam int TS   = 2;
`ifdef SRAM_ACCESS_CTRL_WRITE_VERIFY_EN
  localparam bit V = 1'b1;
`else
  localparam bit V = 1'b0;
`endif
  localparam int LAT_R = TP + TW + TS;
  localparam int LAT_W = V ? (2 * TP + 2 * TW + TS) : (TP + TW);

  typedef struct {
    logic       we;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid, req_ready, req_we;
  logic [3:0]      req_addr;
  logic [COLS-1:0] req_wdata;
  logic            rsp_valid, rsp_err;
  logic [COLS-1:0] rsp_rdata;
  logic            pre_en, wl_en, wr_en, sae;
  logic [3:0]      wl_addr;
  logic [COLS-1:0] wr_data, sa_data;

  int errors = 0;
  int checks = 0;

  // Array model: wordline+write driver stores a row; sense amps read the last selected row.
  logic [7:0] arr [ROWS];
  logic [3:0] row_q;
  logic [7:0] stuck = 8'h00;
  logic [7:0] ref_mem [ROWS];
  logic [7:0] hold;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wl_en) begin
      row_q <= wl_addr;
      if (wr_en) arr[wl_addr] <= wr_data;
    end
  end
  assign sa_data = arr[row_q] & ~stuck;

  sram_access_ctrl #(.COLS(COLS), .ROWS(ROWS), .T_PRE(TP), .T_WL(TW), .T_SA(TS)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .pre_en(pre_en), .wl_en(wl_en), .wl_addr(wl_addr), .wr_en(wr_en),
    .wr_data(wr_data), .sae(sae), .sa_data(sa_data)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic check_inv();
    check("phase_excl", 32'(pre_en) + 32'(wl_en) + 32'(sae) > 1, 0);
    check("wr_without_wl", 32'(wr_en && !wl_en), 0);
    if (!wl_en) begin
      check("wl_addr_idle", 32'(wl_addr), 0);
      check("wr_data_idle", 32'(wr_data), 0);
    end
  endtask

  // One request/response; phase lengths, latency and response fields are checked.
  task automatic do_op(input logic we, input logic [3:0] addr, input logic [7:0] wdata,
                       input logic [7:0] exp_rd, input logic exp_err);
    int  lat, npre, nwl, nsae;
    bit  ok, got;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) ok = 1;
    end
    check("ready_timeout", 32'(ok), 1);
    if (!ok) return;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0; npre = 0; nwl = 0; nsae = 0; got = 0;
    for (int k = 0; k < 60 && !got; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      check_inv();
      if (rsp_valid) begin
        got = 1; lat = k;
      end else begin
        if (pre_en) npre++;
        if (sae) nsae++;
        if (wl_en) begin
          check("wl_addr", 32'(wl_addr), 32'(addr));
          check("wr_data", 32'(wr_data), (we && nwl < TW) ? 32'(wdata) : 0);
          nwl++;
        end
      end
    end
    check("latency", got ? lat : -1, we ? LAT_W : LAT_R);
    check("pre_cycles", npre, (we && V) ? 2 * TP : TP);
    check("wl_cycles", nwl, (we && V) ? 2 * TW : TW);
    check("sae_cycles", nsae, (!we || V) ? TS : 0);
    check("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
    check("rsp_err", 32'(rsp_err), 32'(exp_err));
    @(posedge clk); #1;
    check("rsp_pulse", 32'(rsp_valid), 0);
    check("ready_after", 32'(req_ready), 1);
  endtask

  vec_t vecs [10];

  initial begin
    int n1, n2, r, acc2, pulses;
    bit found;
    logic we_r;
    logic [3:0] a_r;
    logic [7:0] d_r;

    vecs[0] = '{1'b1, 4'd3,  8'hA5, 8'h00};
    vecs[1] = '{1'b0, 4'd3,  8'h00, 8'hA5};
    vecs[2] = '{1'b1, 4'd0,  8'h5A, 8'h00};
    vecs[3] = '{1'b1, 4'd15, 8'hFF, 8'h00};
    vecs[4] = '{1'b0, 4'd15, 8'h00, 8'hFF};
    vecs[5] = '{1'b0, 4'd0,  8'h00, 8'h5A};
    vecs[6] = '{1'b1, 4'd3,  8'h00, 8'h00};
    vecs[7] = '{1'b0, 4'd3,  8'h00, 8'h00};
    vecs[8] = '{1'b1, 4'd8,  8'hC3, 8'h00};
    vecs[9] = '{1'b0, 4'd8,  8'h00, 8'hC3};

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    hold = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(req_ready), 0);
    check("rst_outs", 32'({pre_en, wl_en, wr_en, sae, rsp_valid, rsp_err}), 0);
    check("rst_rdata", 32'(rsp_rdata), 0);
    check("rst_wl_addr", 32'(wl_addr), 0);
    check("rst_wr_data", 32'(wr_data), 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("ready_first_edge", 32'(req_ready), 1);

    // Directed table of writes and reads.
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].we) begin
        if (V) hold = vecs[i].wdata;
        do_op(1'b1, vecs[i].addr, vecs[i].wdata, hold, 1'b0);
        ref_mem[vecs[i].addr] = vecs[i].wdata;
      end else begin
        hold = vecs[i].exp_rd;
        do_op(1'b0, vecs[i].addr, 8'h00, hold, 1'b0);
      end
    end

    // Request held through a busy read, second request queued behind it.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd3; req_wdata = 8'h00;
    @(posedge clk); #1;
    req_we = 1'b1; req_addr = 4'd9; req_wdata = 8'h3C;
    n1 = -1; n2 = -1; r = -1; acc2 = -1; pulses = 0;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (k == acc2) req_valid = 1'b0;
      if (rsp_valid) begin
        pulses++;
        if (n1 < 0) begin
          n1 = k;
          check("b2b_rdata", 32'(rsp_rdata), 32'(ref_mem[3]));
        end else n2 = k;
      end
      if (r < 0 && req_ready) begin r = k; acc2 = k + 1; end
    end
    req_valid = 1'b0;
    check("b2b_lat1", n1, LAT_R);
    check("b2b_ready_idle", r, LAT_R + 1);
    check("b2b_lat2", n2 - acc2, LAT_W);
    check("b2b_pulses", pulses, 2);
    ref_mem[9] = 8'h3C;
    hold = V ? 8'h3C : ref_mem[3];
    do_op(1'b0, 4'd9, 8'h00, 8'h3C, 1'b0);
    hold = 8'h3C;

    // Reset asserted mid-write while the wordline is up.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd5; req_wdata = 8'h77;
    @(posedge clk); #1;
    req_valid = 1'b0;
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(posedge clk); #1;
      if (wl_en) found = 1;
    end
    check("rst_wl_seen", 32'(found), 1);
    #2; rst = 1'b1; #1;
    check("async_drop", 32'({pre_en, wl_en, wr_en, sae}), 0);
    check("async_ready", 32'(req_ready), 0);
    pulses = 0;
    repeat (3) begin @(negedge clk); if (rsp_valid) pulses++; end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_rst", 32'(req_ready), 1);
    check("rdata_after_rst", 32'(rsp_rdata), 0);
    repeat (10) begin @(posedge clk); #1; if (rsp_valid) pulses++; end
    check("no_rsp_after_rst", pulses, 0);
    hold = ref_mem[3];
    do_op(1'b0, 4'd3, 8'h00, hold, 1'b0);
    ref_mem[5] = 8'h11;
    if (V) hold = 8'h11;
    do_op(1'b1, 4'd5, 8'h11, hold, 1'b0);

    // Stuck-at-0 on sense bit 0 is caught only by the verify readback.
    stuck = 8'h01;
    if (V) hold = 8'h00;
    do_op(1'b1, 4'd2, 8'h01, hold, V);
    stuck = 8'h00;
    if (V) hold = 8'h01;
    do_op(1'b1, 4'd2, 8'h01, hold, 1'b0);
    ref_mem[2] = 8'h01;

    // Random mix against a per-row scoreboard; every row is written first.
    for (int i = 0; i < ROWS; i++) begin
      d_r = 8'($urandom);
      if (V) hold = d_r;
      do_op(1'b1, 4'(i), d_r, hold, 1'b0);
      ref_mem[i] = d_r;
    end
    for (int i = 0; i < 500; i++) begin
      we_r = 1'($urandom_range(0, 1));
      a_r  = 4'($urandom_range(0, ROWS - 1));
      d_r  = 8'($urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      if (we_r) begin
        if (V) hold = d_r;
        do_op(1'b1, a_r, d_r, hold, 1'b0);
        ref_mem[a_r] = d_r;
      end else begin
        hold = ref_mem[a_r];
        do_op(1'b0, a_r, 8'h00, hold, 1'b0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
